// File: rtl/mips_wb_pkg.sv
// Shared types and widths for the register-file write-back path.
//   REG_W      : register-address width
//   DATA_W     : register data width
//   wb_entry_t : one queued long-latency result {rd, data}
package mips_wb_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries (long-latency results).
//   clk_i, reset_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i  : enqueue din_i when push_i and not full
//   pop_i          : dequeue head when pop_i and not empty
//   head_o         : entry at the read pointer (valid only when !empty_o)
//   full_o         : count == DEPTH (from registered count)
//   empty_o        : count == 0
module wb_fifo
   import mips_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      reset_i,
   input  logic      push_i,
   input  wb_entry_t din_i,
   input  logic      pop_i,
   output wb_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [PW-1:0] MASK = PW'(DEPTH - 1);

   wb_entry_t       mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q + PW'(1)) & MASK;
      if (do_pop)  rd_ptr_d = (rd_ptr_q + PW'(1)) & MASK;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back sequencer for the register-file write port.
// Merges single-cycle ALU results (A) with queued long-latency results (B),
// one write per cycle, and tracks destinations awaiting B results.
//   clk, reset               : clock, synchronous active-high reset
//   a_valid/a_rd/a_data      : ALU result (no backpressure; A has priority)
//   a_stall                  : asks control to hold off A (B starving)
//   b_valid/b_ready/b_rd/b_data : long-latency result handshake into FIFO
//   iss_valid/iss_rd         : long-latency issue, marks iss_rd pending
//   q_rs/q_rt, hazard        : decode sources, hazard if either is pending
//   pending                  : scoreboard of registers awaiting B results
//   waw_err                  : sticky write-after-write violation flag
//   RegWrite/write_reg/write_data : registered register-file write port
module regfile_writeback
   import mips_wb_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_LIM = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [REG_W-1:0]  a_rd,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_stall,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [REG_W-1:0]  b_rd,
   input  logic [DATA_W-1:0] b_data,
   input  logic              iss_valid,
   input  logic [REG_W-1:0]  iss_rd,
   input  logic [REG_W-1:0]  q_rs,
   input  logic [REG_W-1:0]  q_rt,
   output logic              hazard,
   output logic [31:0]       pending,
   output logic              waw_err,
   output logic              RegWrite,
   output logic [REG_W-1:0]  write_reg,
   output logic [DATA_W-1:0] write_data
);

   localparam int unsigned SW = $clog2(STARVE_LIM + 2);

   wb_entry_t         head;
   wb_entry_t         b_entry;
   logic              fifo_full, fifo_empty;
   logic              push, pop, a_win;

   logic [31:0]       pending_q, pending_d;
   logic              waw_q, waw_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              regwrite_q, regwrite_d;
   logic [REG_W-1:0]  wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   assign b_entry = '{rd: b_rd, data: b_data};

   // b_ready depends on registered count only: a full FIFO refuses a push
   // even in a cycle where it pops.
   assign b_ready = !fifo_full;
   assign push    = b_valid && b_ready;
   // Any a_valid (including a_rd==0) blocks the FIFO for that cycle.
   assign a_win   = a_valid && (a_rd != '0);
   assign pop     = !a_valid && !fifo_empty;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push),
      .din_i   (b_entry),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      // Scoreboard: clear on pop first so a same-cycle issue of the same reg wins.
      pending_d = pending_q;
      if (pop && head.rd != '0)          pending_d[head.rd] = 1'b0;
      if (iss_valid && iss_rd != '0)     pending_d[iss_rd]  = 1'b1;

      waw_d = waw_q
            | (a_win && pending_q[a_rd])
            | (iss_valid && (iss_rd != '0) && pending_q[iss_rd]);

      // Counts cycles a non-empty FIFO is blocked by A; saturates at the limit.
      starve_d = starve_q;
      if (fifo_empty || pop)
         starve_d = '0;
      else if (a_valid && starve_q < SW'(STARVE_LIM))
         starve_d = starve_q + SW'(1);

      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      if (a_win) begin
         regwrite_d = 1'b1;
         wreg_d     = a_rd;
         wdata_d    = a_data;
      end else if (pop && head.rd != '0) begin
         regwrite_d = 1'b1;
         wreg_d     = head.rd;
         wdata_d    = head.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         waw_q      <= 1'b0;
         starve_q   <= '0;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
      end else begin
         pending_q  <= pending_d;
         waw_q      <= waw_d;
         starve_q   <= starve_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
      end
   end

   assign a_stall    = (starve_q >= SW'(STARVE_LIM));
   assign hazard     = pending_q[q_rs] | pending_q[q_rt];
   assign pending    = pending_q;
   assign waw_err    = waw_q;
   assign RegWrite   = regwrite_q;
   assign write_reg  = wreg_q;
   assign write_data = wdata_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4, STARVE_LIM=3).
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        a_stall;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  q_rs, q_rt;
   logic        hazard;
   logic [31:0] pending;
   logic        waw_err;
   logic        RegWrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   int errors = 0;
   int checks = 0;

   regfile_writeback #(
      .DEPTH      (4),
      .STARVE_LIM (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .a_valid    (a_valid),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .a_stall    (a_stall),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .q_rs       (q_rs),
      .q_rt       (q_rt),
      .hazard     (hazard),
      .pending    (pending),
      .waw_err    (waw_err),
      .RegWrite   (RegWrite),
      .write_reg  (write_reg),
      .write_data (write_data)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      chk({tag, ".we"},   {31'd0, RegWrite}, {31'd0, we});
      chk({tag, ".reg"},  {27'd0, write_reg}, {27'd0, wr});
      chk({tag, ".data"}, write_data, wd);
   endtask

   initial begin
      reset = 1'b1; a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
      iss_valid = 1'b0; iss_rd = '0; q_rs = '0; q_rt = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      chk_wr("rst", 1'b0, 5'd0, 32'h0);
      chk("rst.pending", pending, 32'h0);
      chk("rst.waw", {31'd0, waw_err}, 32'd0);
      chk("rst.b_ready", {31'd0, b_ready}, 32'd1);
      chk("rst.a_stall", {31'd0, a_stall}, 32'd0);

      // A only
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
      step();
      chk_wr("a_only", 1'b1, 5'd5, 32'h1234);
      a_rd = 5'd0; a_data = 32'hFFFF;
      step();
      chk_wr("a_rd0", 1'b0, 5'd5, 32'h1234);
      a_valid = 1'b0;

      // Issue / complete
      iss_valid = 1'b1; iss_rd = 5'd8;
      step();
      iss_valid = 1'b0;
      chk("iss.pending", pending, 32'h0000_0100);
      q_rs = 5'd8; q_rt = 5'd0;
      #1;
      chk("iss.hazard_rs", {31'd0, hazard}, 32'd1);
      q_rs = 5'd3; q_rt = 5'd8;
      #1;
      chk("iss.hazard_rt", {31'd0, hazard}, 32'd1);
      q_rt = 5'd0;
      #1;
      chk("iss.no_hazard", {31'd0, hazard}, 32'd0);
      b_valid = 1'b1; b_rd = 5'd8; b_data = 32'hCAFE;
      step();
      b_valid = 1'b0;
      chk("cmp.+1_we", {31'd0, RegWrite}, 32'd0);
      chk("cmp.+1_pending", pending, 32'h0000_0100);
      step();
      chk_wr("cmp.+2", 1'b1, 5'd8, 32'hCAFE);
      chk("cmp.+2_pending", pending, 32'h0);

      // Full FIFO with A valid every cycle
      a_valid = 1'b1; a_rd = 5'd1; b_valid = 1'b1;
      a_data = 32'hA0; b_rd = 5'd10; b_data = 32'hB0;
      step();
      chk_wr("full.e1", 1'b1, 5'd1, 32'hA0);
      chk("full.e1_ready", {31'd0, b_ready}, 32'd1);
      chk("full.e1_stall", {31'd0, a_stall}, 32'd0);
      a_data = 32'hA1; b_rd = 5'd11; b_data = 32'hB1;
      step();
      chk("full.e2_ready", {31'd0, b_ready}, 32'd1);
      chk("full.e2_stall", {31'd0, a_stall}, 32'd0);
      a_data = 32'hA2; b_rd = 5'd12; b_data = 32'hB2;
      step();
      chk("full.e3_ready", {31'd0, b_ready}, 32'd1);
      chk("full.e3_stall", {31'd0, a_stall}, 32'd0);
      a_data = 32'hA3; b_rd = 5'd13; b_data = 32'hB3;
      step();
      chk_wr("full.e4", 1'b1, 5'd1, 32'hA3);
      chk("full.e4_ready", {31'd0, b_ready}, 32'd0);
      chk("full.e4_stall", {31'd0, a_stall}, 32'd1);
      // A asserted despite a_stall: A still wins; offered B is refused (full)
      a_data = 32'hA4; b_rd = 5'd20; b_data = 32'hBAD;
      step();
      chk_wr("full.a_override", 1'b1, 5'd1, 32'hA4);
      chk("full.stall_hold", {31'd0, a_stall}, 32'd1);
      // Drain; b_valid stays up while full at the first pop edge
      a_valid = 1'b0;
      step();
      b_valid = 1'b0;
      chk_wr("drain0", 1'b1, 5'd10, 32'hB0);
      chk("drain0.stall", {31'd0, a_stall}, 32'd0);
      chk("drain0.ready", {31'd0, b_ready}, 32'd1);
      step();
      chk_wr("drain1", 1'b1, 5'd11, 32'hB1);
      step();
      chk_wr("drain2", 1'b1, 5'd12, 32'hB2);
      step();
      chk_wr("drain3", 1'b1, 5'd13, 32'hB3);
      step();
      chk_wr("drain_empty", 1'b0, 5'd13, 32'hB3);
      chk("drain.pending", pending, 32'h0);
      chk("drain.waw", {31'd0, waw_err}, 32'd0);

      // Set wins over clear on the same register
      b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
      step();
      b_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd9;
      step();
      iss_valid = 1'b0;
      chk_wr("setwin.pop", 1'b1, 5'd9, 32'h99);
      chk("setwin.pending", pending, 32'h0000_0200);
      chk("setwin.waw0", {31'd0, waw_err}, 32'd0);
      iss_valid = 1'b1; iss_rd = 5'd9;
      step();
      iss_valid = 1'b0;
      chk("waw.set", {31'd0, waw_err}, 32'd1);
      step();
      chk("waw.sticky", {31'd0, waw_err}, 32'd1);

      // Register 0 handling
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h5555;
      step();
      b_valid = 1'b0;
      step();
      chk_wr("reg0.pop", 1'b0, 5'd9, 32'h99);
      chk("reg0.ready", {31'd0, b_ready}, 32'd1);
      iss_valid = 1'b1; iss_rd = 5'd0;
      step();
      iss_valid = 1'b0;
      chk("reg0.pending", pending, 32'h0000_0200);

      // Reset mid-run with three queued entries
      a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
      b_valid = 1'b1; b_rd = 5'd14; b_data = 32'hE0;
      iss_valid = 1'b1; iss_rd = 5'd14;
      step();
      iss_valid = 1'b0;
      b_rd = 5'd15; b_data = 32'hE1;
      step();
      b_rd = 5'd16; b_data = 32'hE2;
      step();
      chk("mid.pending", pending, 32'h0000_4200);
      a_valid = 1'b0; b_valid = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      chk_wr("mid.rst", 1'b0, 5'd0, 32'h0);
      chk("mid.rst_pending", pending, 32'h0);
      chk("mid.rst_ready", {31'd0, b_ready}, 32'd1);
      chk("mid.rst_waw", {31'd0, waw_err}, 32'd0);
      step();
      chk("mid.after_we", {31'd0, RegWrite}, 32'd0);
      chk("mid.after_stall", {31'd0, a_stall}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
